cle_pin_serializer: RTL
=======================

// Module: cle_pin_serializer
// PURPOSE
//   CLE-side pin-reduction transmitter. Takes parallel ROM-address, SRAM-address and SRAM-data
//   requests from the labeling core and serializes them MSB-first onto 1-bit pins, with a 2-bit
//   Dtype tag selecting which off-chip shift register captures each bit.
//   Sits between the CLE core and the chip pins; the board-side deserializer rebuilds the buses.
// PARAMETERS
//   ROM_AW   7   ROM address width, bits sent on rom_a_o
//   SRAM_AW  10  SRAM address width, bits sent on sram_a_o
//   DW       8   SRAM write-data width, bits sent on sram_d_o
// PORTS
//   clk          in   1        clock; outputs change on posedge, receiver samples on negedge
//   reset        in   1        asynchronous, active-high
//   rom_req      in   1        ROM address transfer request; held until rom_ack
//   rom_addr     in   ROM_AW   ROM address, captured at accept
//   rom_ack      out  1        1-cycle pulse: ROM address fully shifted out
//   sram_rd_req  in   1        SRAM read-address transfer request; held until sram_ack
//   sram_wr_req  in   1        SRAM write request (address + data + write strobe); held until sram_ack
//   sram_addr    in   SRAM_AW  SRAM address, captured at accept
//   sram_wdata   in   DW       SRAM write data, captured at accept
//   sram_ack     out  1        1-cycle pulse: SRAM transaction complete
//   rom_a_o      out  1        serial ROM address bit
//   sram_a_o     out  1        serial SRAM address bit
//   sram_d_o     out  1        serial SRAM data bit
//   sram_wen_o   out  1        SRAM write enable, active-low
//   Dtype_o      out  2        0 idle/guard, 1 ROM addr bit, 2 SRAM addr bit, 3 SRAM data bit
//   busy         out  1        high in every state except IDLE
// BEHAVIOUR
//   Reset: all outputs 0 except sram_wen_o=1; state IDLE; shift regs and counter cleared.
//   Reset mid-transfer aborts at once: no ack is issued, Dtype_o returns to 0.
//   States: IDLE, ROM_SH, SA_SH, SA_GRD, SD_SH, WEN.
//   IDLE: Dtype_o=0. Arbitration is sampled at posedge, fixed priority:
//     sram_wr_req > sram_rd_req > rom_req. The winner's operands are loaded into the shift register
//     and the bit counter.
//   ROM_SH: 7 cycles, Dtype_o=1, rom_a_o=bit[ROM_AW-1-k] in cycle k.
//     Next cycle: IDLE, with rom_ack=1 and Dtype_o=0.
//   SA_SH: 10 cycles, Dtype_o=2, sram_a_o MSB first. Then SA_GRD, exactly 1 cycle, Dtype_o=0.
//     The guard cycle is mandatory; the receiver latches the address on that cycle's negedge.
//     Read: sram_ack=1 in SA_GRD, next state IDLE.
//     Write: SA_GRD goes to SD_SH, no ack.
//   SD_SH: 8 cycles, Dtype_o=3, sram_d_o MSB first. Then WEN.
//   WEN: 1 cycle, Dtype_o=0, sram_wen_o=0, sram_ack=1; next state IDLE.
//   Latency, first serial bit to ack: ROM 7 cycles; SRAM read 10; SRAM write 19. Accept cycle adds 1.
//   Pins not selected by Dtype_o are driven 0. Ack is asserted only while its Dtype_o=0.
//   A request raised in an ack cycle is serviced by the next IDLE arbitration; min gap is 1 idle cycle.
//   Requests deasserted before ack are ignored once accepted; the captured operands are used.
//   Operands changing during a transfer have no effect.
//   Simultaneous sram_rd_req and sram_wr_req: the write wins, and the read waits for the next IDLE.
// TESTING
//   1. After reset with no req: Dtype_o=0, sram_wen_o=1, busy=0 for 20 cycles.
//   2. rom_req, rom_addr=7'h55: Dtype_o=1 for 7 cycles, bits 1010101, then rom_ack.
//      Receiver shift register holds 7'h55.
//   3. sram_rd_req, addr=10'h2C3: 10 bits of Dtype_o=2 (1011000011), 1 guard cycle with sram_ack.
//      Receiver latched address equals 10'h2C3.
//   4. sram_wr_req, addr=10'h3FF, wdata=8'hA5: sequence is 10 addr bits, guard, 8 data bits
//      (10100101), then 1 cycle sram_wen_o=0. After this, mem[1023]=8'hA5 and ack is 19 cycles
//      after the first bit.
//   5. rom_req, sram_rd_req and sram_wr_req all high: the write is serviced first, then the read,
//      then ROM. Each ack fires exactly once.
//   6. Reset asserted at bit 4 of SD_SH: outputs go to reset values immediately, no sram_ack, and
//      no SRAM write occurs.

Source files
------------

// File: rtl/cle_pin_serializer.sv
// cle_pin_serializer: serializes ROM/SRAM address and SRAM data requests MSB-first onto 1-bit pins tagged by Dtype_o
module cle_pin_serializer #(
    parameter int ROM_AW  = 7,
    parameter int SRAM_AW = 10,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rom_req,
    input  logic [ROM_AW-1:0]  rom_addr,
    output logic               rom_ack,
    input  logic               sram_rd_req,
    input  logic               sram_wr_req,
    input  logic [SRAM_AW-1:0] sram_addr,
    input  logic [DW-1:0]      sram_wdata,
    output logic               sram_ack,
    output logic               rom_a_o,
    output logic               sram_a_o,
    output logic               sram_d_o,
    output logic               sram_wen_o,
    output logic [1:0]         Dtype_o,
    output logic               busy
);
    localparam int AW = (SRAM_AW > DW) ? SRAM_AW : DW;
    localparam int MW = (AW > ROM_AW) ? AW : ROM_AW;
    localparam int CW = $clog2(MW + 1);

    typedef enum logic [2:0] {IDLE, ROM_SH, SA_SH, SA_GRD, SD_SH, WEN} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [ROM_AW-1:0]  rom_sh_q;
    logic [SRAM_AW-1:0] sa_sh_q;
    logic [DW-1:0]      sd_sh_q;
    logic               wr_q;

    assign busy = state_q != IDLE;

    // Transfer FSM: every pin and ack is registered; cnt_q holds bits remaining after the one on the pin.
    // The rom_ack cycle is IDLE but must not arbitrate, or a still-held rom_req would be re-accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rom_sh_q   <= '0;
            sa_sh_q    <= '0;
            sd_sh_q    <= '0;
            wr_q       <= 1'b0;
            rom_ack    <= 1'b0;
            sram_ack   <= 1'b0;
            rom_a_o    <= 1'b0;
            sram_a_o   <= 1'b0;
            sram_d_o   <= 1'b0;
            sram_wen_o <= 1'b1;
            Dtype_o    <= 2'd0;
        end else begin
            rom_ack    <= 1'b0;
            sram_ack   <= 1'b0;
            rom_a_o    <= 1'b0;
            sram_a_o   <= 1'b0;
            sram_d_o   <= 1'b0;
            sram_wen_o <= 1'b1;
            Dtype_o    <= 2'd0;
            case (state_q)
                IDLE: begin
                    if (!rom_ack && (sram_wr_req || sram_rd_req)) begin
                        wr_q     <= sram_wr_req;
                        sa_sh_q  <= sram_addr << 1;
                        sd_sh_q  <= sram_wdata;
                        sram_a_o <= sram_addr[SRAM_AW-1];
                        Dtype_o  <= 2'd2;
                        cnt_q    <= CW'(SRAM_AW - 1);
                        state_q  <= SA_SH;
                    end else if (!rom_ack && rom_req) begin
                        rom_sh_q <= rom_addr << 1;
                        rom_a_o  <= rom_addr[ROM_AW-1];
                        Dtype_o  <= 2'd1;
                        cnt_q    <= CW'(ROM_AW - 1);
                        state_q  <= ROM_SH;
                    end
                end
                ROM_SH: begin
                    if (cnt_q == '0) begin
                        rom_ack <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        rom_a_o  <= rom_sh_q[ROM_AW-1];
                        rom_sh_q <= rom_sh_q << 1;
                        Dtype_o  <= 2'd1;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                SA_SH: begin
                    if (cnt_q == '0) begin
                        sram_ack <= !wr_q;
                        state_q  <= SA_GRD;
                    end else begin
                        sram_a_o <= sa_sh_q[SRAM_AW-1];
                        sa_sh_q  <= sa_sh_q << 1;
                        Dtype_o  <= 2'd2;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                SA_GRD: begin
                    if (wr_q) begin
                        sram_d_o <= sd_sh_q[DW-1];
                        sd_sh_q  <= sd_sh_q << 1;
                        Dtype_o  <= 2'd3;
                        cnt_q    <= CW'(DW - 1);
                        state_q  <= SD_SH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SD_SH: begin
                    if (cnt_q == '0) begin
                        sram_wen_o <= 1'b0;
                        sram_ack   <= 1'b1;
                        state_q    <= WEN;
                    end else begin
                        sram_d_o <= sd_sh_q[DW-1];
                        sd_sh_q  <= sd_sh_q << 1;
                        Dtype_o  <= 2'd3;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                WEN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
